// File: rtl/seg_display_arbiter.sv
// Two-requester arbiter for a shared 4-digit multiplexed 7-segment display.
// SEG_ARB_ANTIGHOST_EN inserts one blank cycle at each digit change.
module seg_display_arbiter #(
    parameter int SCAN_DIV   = 100000,
    parameter int HOLD_TICKS = 500
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                last_b;
    logic [DIV_W-1:0]    div;
    logic [1:0]          idx;
    logic [HOLD_W-1:0]   hold;
    logic                tick;
    logic                hold_full;
    logic [7:0]          seg_nxt;
    logic [3:0]          an_nxt;

    assign tick      = (div == DIV_W'(SCAN_DIV - 1));
    assign hold_full = (hold == HOLD_W'(HOLD_TICKS));

    function automatic logic [7:0] pick_byte(input logic [31:0] d, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = d[31:24];
            2'd1:    b = d[23:16];
            2'd2:    b = d[15:8];
            default: b = d[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [3:0] an_of(input logic [1:0] i);
        logic [3:0] a;
        case (i)
            2'd0:    a = 4'b0111;
            2'd1:    a = 4'b1011;
            2'd2:    a = 4'b1101;
            default: a = 4'b1110;
        endcase
        return a;
    endfunction

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_a && req_b)  state_nxt = last_b ? OWN_A : OWN_B;
                else if (req_a)      state_nxt = OWN_A;
                else if (req_b)      state_nxt = OWN_B;
            end
            OWN_A: begin
                if (!req_a)                  state_nxt = req_b ? OWN_B : IDLE;
                else if (req_b && hold_full) state_nxt = OWN_B;
            end
            OWN_B: begin
                if (!req_b)                  state_nxt = req_a ? OWN_A : IDLE;
                else if (req_a && hold_full) state_nxt = OWN_A;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Display follows the post-edge owner so grant and pattern switch together.
    always_comb begin
        seg_nxt = 8'hFF;
        an_nxt  = 4'hF;
        unique case (state_nxt)
            OWN_A: begin
                seg_nxt = pick_byte(data_a, idx);
                an_nxt  = an_of(idx);
            end
            OWN_B: begin
                seg_nxt = pick_byte(data_b, idx);
                an_nxt  = an_of(idx);
            end
            default: ;
        endcase
`ifdef SEG_ARB_ANTIGHOST_EN
        if (tick) begin
            seg_nxt = 8'hFF;
            an_nxt  = 4'hF;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state  <= IDLE;
            last_b <= 1'b1;
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            seg    <= 8'hFF;
            an     <= 4'hF;
            div    <= '0;
            idx    <= 2'd0;
            hold   <= '0;
        end else begin
            state <= state_nxt;
            gnt_a <= (state_nxt == OWN_A);
            gnt_b <= (state_nxt == OWN_B);
            seg   <= seg_nxt;
            an    <= an_nxt;
            div   <= tick ? '0 : div + 1'b1;
            if (tick) idx <= idx + 2'd1;
            if (state_nxt == OWN_A)      last_b <= 1'b0;
            else if (state_nxt == OWN_B) last_b <= 1'b1;
            if (state_nxt != state || state_nxt == IDLE) hold <= '0;
            else if (tick && !hold_full)                 hold <= hold + 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench: cycle-level reference model feeds an expectation queue; monitor compares.
module tb_seg_display_arbiter;

    localparam int SD = 4;
    localparam int HT = 2;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        req_a, req_b;
    logic [31:0] data_a, data_b;
    logic        gnt_a, gnt_b;
    logic [7:0]  seg;
    logic [3:0]  an;

    seg_display_arbiter #(.SCAN_DIV(SD), .HOLD_TICKS(HT)) dut (
        .CLK(CLK), .RSTN(RSTN), .req_a(req_a), .req_b(req_b),
        .data_a(data_a), .data_b(data_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
        .seg(seg), .an(an)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       ga;
        logic       gb;
        logic [7:0] seg;
        logic [3:0] an;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model: owner 0=none 1=A 2=B; n counts edges since reset.
    int m_owner, m_last, m_hold, m_n;

    task automatic step(input logic rst_n, input logic ra, input logic rb,
                        input logic [31:0] da, input logic [31:0] db);
        exp_t e;
        int   nxt, digit;
        bit   tick;
        logic [31:0] d;
        @(negedge CLK);
        RSTN = rst_n; req_a = ra; req_b = rb; data_a = da; data_b = db;
        e.cyc = cyc;
        if (!rst_n) begin
            m_owner = 0; m_last = 2; m_hold = 0; m_n = 0;
            e.ga = 0; e.gb = 0; e.seg = 8'hFF; e.an = 4'hF;
        end else begin
            tick  = (m_n % SD) == SD - 1;
            digit = (m_n / SD) % 4;
            nxt   = m_owner;
            if (m_owner == 0) begin
                if (ra && rb)  nxt = (m_last == 2) ? 1 : 2;
                else if (ra)   nxt = 1;
                else if (rb)   nxt = 2;
            end else if (m_owner == 1) begin
                if (!ra)                   nxt = rb ? 2 : 0;
                else if (rb && m_hold == HT) nxt = 2;
            end else begin
                if (!rb)                   nxt = ra ? 1 : 0;
                else if (ra && m_hold == HT) nxt = 1;
            end
            if (nxt != m_owner || nxt == 0)    m_hold = 0;
            else if (tick && m_hold < HT)      m_hold++;
            if (nxt != 0) m_last = nxt;
            m_owner = nxt;
            m_n++;
            e.ga = (m_owner == 1);
            e.gb = (m_owner == 2);
            if (m_owner == 0) begin
                e.seg = 8'hFF; e.an = 4'hF;
            end else begin
                d     = (m_owner == 1) ? da : db;
                e.seg = 8'((d >> (8 * (3 - digit))) & 32'hFF);
                e.an  = 4'hF & ~(4'b1000 >> digit);
            end
`ifdef SEG_ARB_ANTIGHOST_EN
            if (tick) begin
                e.seg = 8'hFF; e.an = 4'hF;
            end
`endif
        end
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want, input int c);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, c, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            cyc++;
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gnt_a", {7'd0, gnt_a}, {7'd0, e.ga}, e.cyc);
                check("gnt_b", {7'd0, gnt_b}, {7'd0, e.gb}, e.cyc);
                check("seg",   seg,           e.seg,        e.cyc);
                check("an",    {4'd0, an},    {4'd0, e.an}, e.cyc);
                checks++;
                if (gnt_a === 1'b1 && gnt_b === 1'b1) begin
                    failures++;
                    $display("FAIL both_grants cyc=%0d got=11 want=not both", e.cyc);
                end
            end
        end
    end

    initial begin : stim
        logic ra, rb, rs;
        logic [31:0] da, db;
        int budget;
        RSTN = 1'b0; req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0;

        // Reset, then A alone with a fixed pattern: full digit rotation twice.
        repeat (3) step(0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 34; i++) step(1, 1, 0, 32'hC0F9A4B0, 32'h12345678);
        // A releases with nobody waiting -> idle.
        repeat (3) step(1, 0, 0, 32'hC0F9A4B0, 32'h12345678);

        // Fresh reset, simultaneous requests -> A; A releases -> immediate handoff.
        repeat (2) step(0, 1, 1, 32'h11223344, 32'h55667788);
        repeat (3) step(1, 1, 1, 32'h11223344, 32'h55667788);
        repeat (6) step(1, 0, 1, 32'h11223344, 32'h55667788);

        // B owns, A requests: preemption once hold saturates, then back.
        repeat (30) step(1, 1, 1, 32'hA1B2C3D4, 32'hE5F60718);

        // Both drop, then simultaneous request -> non-last owner.
        repeat (3) step(1, 0, 0, 32'hA1B2C3D4, 32'hE5F60718);
        repeat (4) step(1, 1, 1, 32'hA1B2C3D4, 32'hE5F60718);
        repeat (3) step(1, 0, 0, 32'hA1B2C3D4, 32'hE5F60718);
        repeat (4) step(1, 1, 1, 32'hA1B2C3D4, 32'hE5F60718);

        // Reset while B owns, then re-arbitration from a clean state.
        repeat (6) step(1, 0, 1, 32'hA1B2C3D4, 32'hE5F60718);
        step(0, 0, 1, 32'hA1B2C3D4, 32'hE5F60718);
        repeat (12) step(1, 1, 1, 32'hA1B2C3D4, 32'hE5F60718);

        ra = 0; rb = 0; da = $urandom; db = $urandom;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) ra = ~ra;
            if ($urandom_range(0, 7) == 0) rb = ~rb;
            if ($urandom_range(0, 3) == 0) da = $urandom;
            if ($urandom_range(0, 3) == 0) db = $urandom;
            rs = ($urandom_range(0, 299) != 0);
            step(rs, ra, rb, da, db);
        end

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge CLK);
            budget++;
        end
        #2;
        checks++;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0 pending", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
